// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
//
// Purpose:
//   Shared UART definitions for the transmit path (uart_back) and, later, the
//   receive path (uart_front): frame FSM state encoding, data width, the idle
//   line level and a parity helper.
//
// Contents:
//   tx_state_t  - frame FSM states; PARITY is only entered when the parity
//                 option is compiled in.
//   DATA_BITS   - payload bits per frame.
//   UART_IDLE   - level of the serial line between frames (mark).
//   even_parity - even parity bit over one payload byte.
// -----------------------------------------------------------------------------
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } tx_state_t;

    localparam int DATA_BITS = 8;

    localparam logic UART_IDLE = 1'b1;

    // Even parity: the bit that makes the total count of ones even.
    function automatic logic even_parity(input logic [DATA_BITS-1:0] b);
        return ^b;
    endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// -----------------------------------------------------------------------------
// uart_baud_gen
//
// Purpose:
//   Bit-period timer. Counts 0..CLKS_PER_BIT-1 and flags the terminal count
//   so the owning FSM advances exactly once per bit period. Written to be
//   reused by the receiver's sampler.
//
// Parameters:
//   CLKS_PER_BIT - clock cycles per bit period (>= 2).
//
// Ports:
//   clk      in   system clock, rising edge
//   rst      in   synchronous active-high reset
//   clr      in   hold the counter at 0 (asserted while no frame is running)
//   bit_tick out  high on the last cycle of each bit period
// -----------------------------------------------------------------------------
module uart_baud_gen #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    output logic bit_tick
);

    localparam int CNT_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] baud_cnt;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            baud_cnt <= '0;
        end else if (baud_cnt == LAST_CNT) begin
            baud_cnt <= '0;
        end else begin
            baud_cnt <= baud_cnt + CNT_W'(1);
        end
    end

    // While clr holds the counter at 0 the terminal count cannot be reached,
    // because CLKS_PER_BIT is at least 2.
    assign bit_tick = (baud_cnt == LAST_CNT);

endmodule

// File: rtl/uart_back.sv
// -----------------------------------------------------------------------------
// uart_back
//
// Purpose:
//   UART transmitter. Bytes arrive over a valid/ready handshake into a
//   one-byte holding buffer and are serialised LSB first, one start bit,
//   eight data bits, optional even parity bit, STOP_BITS stop bits, at
//   CLKS_PER_BIT clocks per bit. The holding buffer lets the next byte be
//   accepted while the current frame is still shifting, so a waiting byte
//   starts on the cycle right after the previous stop bit (no idle gap).
//
// Build option:
//   UART_BACK_PARITY_EN - when defined, a PARITY bit period carrying the
//                         even parity of the byte is inserted between the
//                         last data bit and the stop bit(s) (8E1/8E2).
//                         When undefined, frames are 8N1/8N2 and no parity
//                         logic is built.
//
// Parameters:
//   CLKS_PER_BIT - clock cycles per bit period (>= 2)
//   STOP_BITS    - stop bits per frame (1 or 2)
//
// Ports:
//   clk         in   system clock, rising edge
//   rst         in   synchronous active-high reset; aborts any frame and
//                    drops a buffered byte
//   data_tx     in   byte to send, sampled when uart_valid && uart_ready
//   uart_valid  in   producer has a byte on data_tx
//   uart_ready  out  holding buffer empty (registered)
//   uart_tx     out  serial line, idles high, driven straight from a flop
//   tx_busy     out  a frame is on the line (FSM not idle)
// -----------------------------------------------------------------------------
module uart_back
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16,
    parameter int STOP_BITS    = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] data_tx,
    input  logic       uart_valid,
    output logic       uart_ready,
    output logic       uart_tx,
    output logic       tx_busy
);

    localparam logic [2:0] LAST_BIT  = 3'(DATA_BITS - 1);
    localparam logic       LAST_STOP = 1'(STOP_BITS - 1);

    tx_state_t            state;
    logic [DATA_BITS-1:0] buf_data;
    logic                 buf_full;
    logic [DATA_BITS-1:0] shift_reg;
    logic [2:0]           bit_idx;
    logic                 stop_idx;
    logic                 bit_tick;
    logic                 baud_clr;
    logic                 stop_done;
    logic                 load;
    logic                 xfer;

`ifdef UART_BACK_PARITY_EN
    logic                 par_bit;
`endif

    // -------------------------------------------------------------------------
    // Bit-period timer. Held at 0 while idle so that a frame loaded from IDLE
    // gets a full-length start bit; when a frame is chained from STOP the
    // counter is already wrapping to 0 on that same edge.
    // -------------------------------------------------------------------------
    assign baud_clr = (state == IDLE);

    uart_baud_gen #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud_gen (
        .clk     (clk),
        .rst     (rst),
        .clr     (baud_clr),
        .bit_tick(bit_tick)
    );

    // -------------------------------------------------------------------------
    // Frame load decision: from IDLE as soon as a byte is waiting, or on the
    // very last cycle of the final stop bit for back-to-back frames.
    // -------------------------------------------------------------------------
    assign xfer      = uart_valid && uart_ready;
    assign stop_done = (state == STOP) && bit_tick && (stop_idx == LAST_STOP);
    assign load      = buf_full && ((state == IDLE) || stop_done);

    // -------------------------------------------------------------------------
    // Holding buffer. A fill and a drain can never land on the same edge:
    // the buffer is only drained while full, and ready is low while full.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            buf_full   <= 1'b0;
            uart_ready <= 1'b1;
        end else if (xfer) begin
            buf_full   <= 1'b1;
            uart_ready <= 1'b0;
        end else if (load) begin
            buf_full   <= 1'b0;
            uart_ready <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (xfer) begin
            buf_data <= data_tx;
        end
    end

    // -------------------------------------------------------------------------
    // Shift register: loaded with the buffered byte, shifted right at the end
    // of every data bit so bit 0 always holds the bit on (or next on) the line.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (load) begin
            shift_reg <= buf_data;
        end else if ((state == DATA) && bit_tick) begin
            shift_reg <= shift_reg >> 1;
        end
    end

`ifdef UART_BACK_PARITY_EN
    always_ff @(posedge clk) begin
        if (load) begin
            par_bit <= even_parity(buf_data);
        end
    end
`endif

    // -------------------------------------------------------------------------
    // Frame FSM. uart_tx is assigned here with the value for the state being
    // entered, so the line comes straight off a flop and changes exactly on
    // bit boundaries.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            uart_tx  <= UART_IDLE;
            tx_busy  <= 1'b0;
            bit_idx  <= '0;
            stop_idx <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (load) begin
                        state    <= START;
                        uart_tx  <= 1'b0;
                        tx_busy  <= 1'b1;
                        bit_idx  <= '0;
                        stop_idx <= 1'b0;
                    end else begin
                        uart_tx <= UART_IDLE;
                        tx_busy <= 1'b0;
                    end
                end

                START: begin
                    if (bit_tick) begin
                        state   <= DATA;
                        uart_tx <= shift_reg[0];
                    end
                end

                DATA: begin
                    if (bit_tick) begin
                        if (bit_idx == LAST_BIT) begin
`ifdef UART_BACK_PARITY_EN
                            state   <= PARITY;
                            uart_tx <= par_bit;
`else
                            state    <= STOP;
                            uart_tx  <= UART_IDLE;
                            stop_idx <= 1'b0;
`endif
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                            // Bit 1 becomes bit 0 after this edge's shift.
                            uart_tx <= shift_reg[1];
                        end
                    end
                end

`ifdef UART_BACK_PARITY_EN
                PARITY: begin
                    if (bit_tick) begin
                        state    <= STOP;
                        uart_tx  <= UART_IDLE;
                        stop_idx <= 1'b0;
                    end
                end
`endif

                STOP: begin
                    if (bit_tick) begin
                        if (stop_idx == LAST_STOP) begin
                            if (load) begin
                                // Chain the next frame without an idle cycle.
                                state   <= START;
                                uart_tx <= 1'b0;
                                bit_idx <= '0;
                            end else begin
                                state   <= IDLE;
                                uart_tx <= UART_IDLE;
                                tx_busy <= 1'b0;
                            end
                        end else begin
                            stop_idx <= stop_idx + 1'b1;
                        end
                    end
                end

                default: begin
                    state   <= IDLE;
                    uart_tx <= UART_IDLE;
                    tx_busy <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_back.sv
// -----------------------------------------------------------------------------
// tb_uart_back
//
// Self-checking bench for uart_back at CLKS_PER_BIT=16, STOP_BITS=1.
// The line is logged once per cycle (on the falling edge); expected line
// waveforms are built bit-by-bit from the frame format, and a behavioural
// receiver decodes the logged line back into bytes for comparison with the
// bytes offered. Honours UART_BACK_PARITY_EN like the design.
// -----------------------------------------------------------------------------
module tb_uart_back;

    localparam int C    = 16;
    localparam int STOP = 1;
`ifdef UART_BACK_PARITY_EN
    localparam int PBITS = 1;
`else
    localparam int PBITS = 0;
`endif
    localparam int FRAME = C * (1 + 8 + PBITS + STOP);

    logic       clk;
    logic       rst;
    logic [7:0] data_tx;
    logic       uart_valid;
    logic       uart_ready;
    logic       uart_tx;
    logic       tx_busy;

    int checks;
    int errors;
    int ferr;

    logic       tx_q[$];
    logic       busy_q[$];
    logic       rdy_q[$];
    logic       exp_q[$];
    logic [7:0] rx_q[$];
    logic [7:0] sent_q[$];

    uart_back #(
        .CLKS_PER_BIT(C),
        .STOP_BITS   (STOP)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .data_tx   (data_tx),
        .uart_valid(uart_valid),
        .uart_ready(uart_ready),
        .uart_tx   (uart_tx),
        .tx_busy   (tx_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout required=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] req);
        checks++;
        assert (obs === req) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, req);
        end
    endtask

    // One clock: wait for the falling edge and log the outputs.
    task automatic step();
        @(negedge clk);
        tx_q.push_back(uart_tx);
        busy_q.push_back(tx_busy);
        rdy_q.push_back(uart_ready);
    endtask

    task automatic run(input int n);
        repeat (n) step();
    endtask

    task automatic clear_logs();
        tx_q.delete();
        busy_q.delete();
        rdy_q.delete();
        exp_q.delete();
        rx_q.delete();
        sent_q.delete();
    endtask

    // Offer a byte and hold valid until it is taken (bounded).
    task automatic send_byte(input logic [7:0] b, input string tag);
        logic acc;
        acc        = 1'b0;
        data_tx    = b;
        uart_valid = 1'b1;
        for (int k = 0; k < 1000 && !acc; k++) begin
            acc = uart_ready;
            step();
        end
        uart_valid = 1'b0;
        check({tag, "_accepted"}, 32'(acc), 32'd1);
    endtask

    // Expected line samples for one frame, straight from the frame format.
    task automatic add_frame(input logic [7:0] b);
        repeat (C) exp_q.push_back(1'b0);
        for (int i = 0; i < 8; i++) repeat (C) exp_q.push_back(b[i]);
`ifdef UART_BACK_PARITY_EN
        repeat (C) exp_q.push_back(^b);
`endif
        repeat (STOP * C) exp_q.push_back(1'b1);
    endtask

    task automatic compare_wave(input string tag, input int start);
        int bad;
        bad = 0;
        for (int j = 0; j < exp_q.size(); j++) begin
            if (start + j >= tx_q.size()) bad++;
            else if (tx_q[start + j] !== exp_q[j]) bad++;
        end
        check(tag, 32'(bad), 32'd0);
    endtask

    function automatic int first_zero();
        for (int i = 0; i < tx_q.size(); i++) if (tx_q[i] == 1'b0) return i;
        return -1;
    endfunction

    function automatic int busy_run(input int start);
        int n;
        n = 0;
        if (start < 0) return 0;
        for (int i = start; i < busy_q.size() && busy_q[i] == 1'b1; i++) n++;
        return n;
    endfunction

    function automatic int count_val(input int which, input logic v);
        int n;
        n = 0;
        if (which == 0) begin
            foreach (tx_q[i]) if (tx_q[i] === v) n++;
        end else if (which == 1) begin
            foreach (busy_q[i]) if (busy_q[i] === v) n++;
        end else begin
            foreach (rdy_q[i]) if (rdy_q[i] === v) n++;
        end
        return n;
    endfunction

    // Behavioural receiver: mid-bit sampling of the logged line.
    task automatic decode();
        int i;
        int mid;
        int last;
        logic [7:0] b;
        rx_q.delete();
        ferr = 0;
        i = 0;
        while (i < tx_q.size()) begin
            if (tx_q[i] == 1'b0) begin
                mid  = i + C / 2;
                last = mid + (8 + PBITS + STOP) * C;
                if (last >= tx_q.size()) break;
                if (tx_q[mid] != 1'b0) ferr++;
                for (int k = 0; k < 8; k++) b[k] = tx_q[mid + (k + 1) * C];
`ifdef UART_BACK_PARITY_EN
                if (tx_q[mid + 9 * C] != ^b) ferr++;
`endif
                for (int s = 0; s < STOP; s++)
                    if (tx_q[mid + (9 + PBITS + s) * C] != 1'b1) ferr++;
                rx_q.push_back(b);
                i = last + 1;
            end else begin
                i++;
            end
        end
    endtask

    task automatic check_rx(input string tag);
        decode();
        check({tag, "_frame_err"}, 32'(ferr), 32'd0);
        check({tag, "_rx_count"}, 32'(rx_q.size()), 32'(sent_q.size()));
        for (int k = 0; k < sent_q.size() && k < rx_q.size(); k++)
            check($sformatf("%s_rx%0d", tag, k), 32'(rx_q[k]), 32'(sent_q[k]));
    endtask

    initial begin
        int fz;
        int acc_idx;
        int gap;
        logic [7:0] b;
        logic [7:0] b96;

        checks     = 0;
        errors     = 0;
        ferr       = 0;
        rst        = 1'b1;
        uart_valid = 1'b0;
        data_tx    = 8'h00;

        // Reset values
        run(3);
        check("rst_tx", 32'(uart_tx), 32'd1);
        check("rst_ready", 32'(uart_ready), 32'd1);
        check("rst_busy", 32'(tx_busy), 32'd0);
        rst = 1'b0;

        // Idle 50 cycles
        clear_logs();
        run(50);
        check("idle_tx_low", 32'(count_val(0, 1'b0)), 32'd0);
        check("idle_busy_high", 32'(count_val(1, 1'b1)), 32'd0);
        check("idle_ready_low", 32'(count_val(2, 1'b0)), 32'd0);

        // Single byte 0x55, valid pulsed for one cycle
        clear_logs();
        sent_q.push_back(8'h55);
        send_byte(8'h55, "b55");
        run(FRAME + 40);
        fz = first_zero();
        check("b55_ready_low_cycles", 32'(count_val(2, 1'b0)), 32'd1);
        check("b55_start_pos", 32'(fz), 32'd1);
        add_frame(8'h55);
        compare_wave("b55_wave", fz);
        check("b55_busy_run", 32'(busy_run(fz)), 32'(FRAME));
        check("b55_busy_total", 32'(count_val(1, 1'b1)), 32'(FRAME));
        check_rx("b55");

        // 0x0F then 0xA3 held: back-to-back
        clear_logs();
        sent_q.push_back(8'h0F);
        sent_q.push_back(8'hA3);
        send_byte(8'h0F, "b0f");
        send_byte(8'hA3, "ba3");
        acc_idx = tx_q.size() - 1;
        run(2 * FRAME + 40);
        fz = first_zero();
        check("b2b_accept_idx", 32'(acc_idx), 32'd2);
        check("b2b_start_pos", 32'(fz), 32'd1);
        add_frame(8'h0F);
        add_frame(8'hA3);
        compare_wave("b2b_wave", fz);
        check("b2b_busy_run", 32'(busy_run(fz)), 32'(2 * FRAME));
        check_rx("b2b");

        // data_tx wiggles with valid low, then 0x9C offered
        clear_logs();
        for (int k = 0; k < 40; k++) begin
            data_tx = 8'($urandom);
            step();
        end
        check("novalid_tx_low", 32'(count_val(0, 1'b0)), 32'd0);
        check("novalid_busy", 32'(count_val(1, 1'b1)), 32'd0);
        sent_q.push_back(8'h9C);
        send_byte(8'h9C, "b9c");
        run(FRAME + 20);
        fz = first_zero();
        check("b9c_start_pos", 32'(fz), 32'd41);
        add_frame(8'h9C);
        compare_wave("b9c_wave", fz);
        check_rx("b9c");

        // Reset during bit 3 of 0x96 with a second byte buffered
        clear_logs();
        b96 = 8'h96;
        send_byte(b96, "b96");
        send_byte(8'h5A, "b5a");
        while (tx_q.size() < 72) step();
        check("b96_bit3", 32'(tx_q[71]), 32'(b96[3]));
        check("b96_buffered", 32'(rdy_q[71]), 32'd0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("midrst_tx", 32'(uart_tx), 32'd1);
        check("midrst_ready", 32'(uart_ready), 32'd1);
        check("midrst_busy", 32'(tx_busy), 32'd0);
        tx_q.delete();
        busy_q.delete();
        run(2 * FRAME);
        check("midrst_no_frame", 32'(count_val(0, 1'b0)), 32'd0);
        check("midrst_no_busy", 32'(count_val(1, 1'b1)), 32'd0);

`ifdef UART_BACK_PARITY_EN
        // Even parity: 0x07 -> 1, 0x03 -> 0
        clear_logs();
        send_byte(8'h07, "p07");
        run(FRAME + 10);
        fz = first_zero();
        begin
            int ones_par;
            int ones_stop;
            ones_par  = 0;
            ones_stop = 0;
            for (int j = 144; j < 160; j++) if (tx_q[fz + j] === 1'b1) ones_par++;
            for (int j = 160; j < 176; j++) if (tx_q[fz + j] === 1'b1) ones_stop++;
            check("p07_parity", 32'(ones_par), 32'd16);
            check("p07_stop", 32'(ones_stop), 32'd16);
        end
        clear_logs();
        send_byte(8'h03, "p03");
        run(FRAME + 10);
        fz = first_zero();
        begin
            int ones_par;
            ones_par = 0;
            for (int j = 144; j < 160; j++) if (tx_q[fz + j] === 1'b1) ones_par++;
            check("p03_parity", 32'(ones_par), 32'd0);
        end
`endif

        // Random bytes with random offer gaps
        clear_logs();
        for (int n = 0; n < 12; n++) begin
            b   = 8'($urandom);
            gap = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 200)) : 0;
            run(gap);
            sent_q.push_back(b);
            send_byte(b, $sformatf("rnd%0d", n));
        end
        run(2 * FRAME + 20);
        check("rnd_busy_total", 32'(count_val(1, 1'b1)), 32'(12 * FRAME));
        check("rnd_end_idle", 32'(tx_q[tx_q.size() - 1]), 32'd1);
        check_rx("rnd");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_back.md
Name: uart_back

Overview:
- UART transmitter; the outbound counterpart of the existing uart_front receiver.
- Accepts bytes over a valid/ready handshake, serialises each as 8N1 (LSB first) on uart_tx at CLKS_PER_BIT clocks per bit.
- One-byte holding buffer lets the next byte be accepted while the current frame shifts out, so consecutive frames go out back-to-back with no idle gap.
- Sits between control/status logic (e.g. reply/echo path of ctl_if) and the board TX pin.

Parameters:
- CLKS_PER_BIT, 16, clock cycles per bit period; legal range >= 2 (160 ns/bit at 10 ns clk).
- STOP_BITS, 1, number of stop bits; legal values 1 or 2.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  reset; synchronous and active-high.
- data_tx  input  8  byte to send; sampled when uart_valid && uart_ready.
- uart_valid  input  1  producer has a byte on data_tx.
- uart_ready  output  1  holding buffer empty; byte accepted this cycle if uart_valid is also high.
- uart_tx  output  1  serial line; idles high.
- tx_busy  output  1  FSM not in IDLE (frame on the line).

Behaviour:
- Reset values: uart_tx=1, uart_ready=1, tx_busy=0, FSM=IDLE, buffer empty, counters 0.
- Reset mid-frame: frame aborted; uart_tx=1 after the reset edge; buffered byte dropped; no partial-frame resume.
- Handshake:
  - Transfer occurs on an edge where uart_valid && uart_ready.
  - uart_ready is registered and equals !buf_full.
  - data_tx must be stable only in the transfer cycle; the producer may hold valid indefinitely.
- Buffer: filled on transfer; emptied on the edge where the FSM loads the shift register. Fill and drain never coincide, because ready is low while full.
- FSM: IDLE, START, DATA, STOP, plus PARITY with the optional feature.
  - IDLE: uart_tx=1. If buf_full at an edge: load shift register, go to START, clear buffer.
  - START: uart_tx=0 for CLKS_PER_BIT cycles, then DATA.
  - DATA: uart_tx = shift[0]; after each CLKS_PER_BIT cycles shift right. After bit 7, go to STOP.
  - STOP: uart_tx=1 for STOP_BITS*CLKS_PER_BIT cycles.
    - On the last cycle, if buf_full: load and go directly to START (no idle gap).
    - Otherwise go to IDLE.
- Latency: byte accepted at edge N with FSM idle -> buffer full after N -> start bit visible after edge N+1. uart_ready is high again after edge N+1.
- Frame length: (10 + STOP_BITS - 1) * CLKS_PER_BIT cycles; 160 cycles at defaults.
- Counters:
  - Baud counter: 0..CLKS_PER_BIT-1; wraps to 0 and asserts an internal bit tick on the terminal count.
  - Bit index: 3 bits, 0..7.
  - No carry is observable outside the block.
- tx_busy = (FSM != IDLE); it remains 1 continuously across back-to-back frames.
- uart_tx is driven directly from a register: no combinational path from inputs, glitch-free.

Optional Feature:
- Macro UART_BACK_PARITY_EN.
- Defined: PARITY state inserted between DATA and STOP, lasting CLKS_PER_BIT cycles. uart_tx = ^byte (even parity). Frame is 8E1/8E2, 176 cycles at defaults.
- Undefined: no PARITY state, 8N1/8N2; parity logic absent.

Decomposition:
- Package uart_pkg:
  - enum tx_state_t {IDLE, START, DATA, PARITY, STOP};
  - constant DATA_BITS=8;
  - idle-level constant UART_IDLE=1'b1.
  - Shared with uart_front for future refactor.
- Sub-module uart_baud_gen:
  - Parameterised CLKS_PER_BIT counter with clear input (asserted on frame load) and a bit_tick output.
  - Reusable by uart_front's sampler.

Test Plan:
- Reset then idle 50 cycles -> uart_tx=1, uart_ready=1, tx_busy=0 throughout.
- Send 0x55 with valid pulsed one cycle.
  - uart_ready low for exactly 1 cycle.
  - Line shows 0,1,0,1,0,1,0,1,0,1, each 16 cycles; tx_busy high 160 cycles.
- Send 0x0F, then hold valid with 0xA3 immediately.
  - 0xA3 accepted during the 0x0F START/DATA phase.
  - 0xA3 start bit begins the cycle after the 0x0F stop bit ends: 320 contiguous busy cycles.
  - A bench uart_front loopback receives 0x0F then 0xA3.
- Hold valid low with 0x9C on data_tx, then raise valid for 1 cycle while ready=1 -> 0x9C framed. With valid low, data_tx changes have no effect on uart_tx.
- Assert rst for 1 cycle at cycle 70 of 0x96 frame (bit 3) with a second byte buffered -> uart_tx=1, ready=1 after the edge; no further frames emitted.
- UART_BACK_PARITY_EN defined, send 0x07 (three ones) -> parity bit=1 at cycles 144-159; stop bit at 160-175. 0x03 -> parity bit=0.
